// File: rtl/dmem_responder.sv
// dmem_responder: slow data-memory target for the core's MEM stage.
// Accepts one load/store per handshake, waits WAIT_CYCLES, then presents a
// response that is held until the requester takes it. Words are stored as
// four byte-lane arrays so per-byte write strobes map onto independent RAMs.
// Addresses at or above DEPTH are reported through rsp_err and never alias.
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;

  // Captured request; valid from the edge after the handshake onward.
  logic [ADDR_W-1:0] adr_reg;
  logic [3:0]        we_reg;
  logic [31:0]       wdata_reg;

  logic              accept;
  logic              enter_resp;

  // Request fields as seen by the array on the edge that enters RESP. With
  // zero wait states that edge is the accept edge itself, so the live inputs
  // must be used because the capture registers are only loaded on that edge.
  logic [ADDR_W-1:0] acc_adr;
  logic [3:0]        acc_we;
  logic [31:0]       acc_wdata;
  logic              acc_in_range;
  logic [IDX_W-1:0]  acc_idx;

  logic              rsp_in_range;
  logic [31:0]       rd_word;

  assign accept = req_valid && req_ready;

  assign acc_adr   = (state_reg == IDLE) ? req_adr   : adr_reg;
  assign acc_we    = (state_reg == IDLE) ? req_we    : we_reg;
  assign acc_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;

  assign acc_in_range = ({1'b0, acc_adr} < DEPTH_L);
  assign acc_idx      = acc_adr[IDX_W-1:0];
  assign rsp_in_range = ({1'b0, adr_reg} < DEPTH_L);

  // Gated by reset so a request dropped by reset on the entry edge never commits.
  assign enter_resp = (state_next == RESP) && (state_reg != RESP) && !reset;

  // State register and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (WAIT_L == 4'd0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_L;
          end
        end
      end
      WAIT: begin
        // A count of 1 means this is the last wait state.
        if (cnt_reg <= 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Outputs decoded from the registered state; data is forced to zero outside
  // a successful load response so reset clears everything immediately.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    case (state_reg)
      IDLE: req_ready = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = !rsp_in_range;
        if (rsp_in_range && (we_reg == 4'b0000)) begin
          rsp_rdata = rd_word;
        end
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // Request capture on handshake; inputs are ignored while not ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adr_reg   <= '0;
      we_reg    <= 4'd0;
      wdata_reg <= 32'd0;
    end else if (accept) begin
      adr_reg   <= req_adr;
      we_reg    <= req_we;
      wdata_reg <= req_wdata;
    end
  end

  // One RAM per byte lane: each lane writes only when its strobe is set, and
  // every lane reads on the RESP entry edge. A store never reads its own
  // write because the response data is suppressed for stores.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_reg;

      // Byte-lane write, committed only on the edge that enters RESP.
      always_ff @(posedge clk) begin
        if (enter_resp && acc_in_range && acc_we[gi]) begin
          lane_mem[acc_idx] <= acc_wdata[8*gi +: 8];
        end
      end

      // Registered byte-lane read, held through the response.
      always_ff @(posedge clk) begin
        if (enter_resp) begin
          lane_rd_reg <= lane_mem[acc_idx];
        end
      end

      assign rd_word[8*gi +: 8] = lane_rd_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Instance a: DEPTH=1024, two wait
// states (range and timing checks). Instance b: zero wait states.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_valid, a_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [3:0]  a_we;
  logic [11:0] a_adr;
  logic [31:0] a_wdata, a_rsp_rdata;

  logic        b_valid, b_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [3:0]  b_we;
  logic [11:0] b_adr;
  logic [31:0] b_wdata, b_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(12), .DEPTH(1024), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_adr(a_adr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.ADDR_W(12), .DEPTH(4096), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_adr(b_adr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance a (sel=0) or b (sel=1). lat counts the
  // rising edges from the handshake edge up to the one that raises rsp_valid.
  task automatic xact(input bit sel, input logic [3:0] we, input logic [11:0] adr,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int lat);
    @(negedge clk);
    if (sel) begin b_valid = 1'b1; b_we = we; b_adr = adr; b_wdata = wd; end
    else     begin a_valid = 1'b1; a_we = we; a_adr = adr; a_wdata = wd; end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    lat = 1;
    while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = sel ? b_rsp_rdata : a_rsp_rdata;
    er = sel ? b_rsp_err : a_rsp_err;
    if (sel) b_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    $display("xact dut=%0d we=%b adr=%h wdata=%h -> rdata=%h err=%b lat=%0d",
             sel, we, adr, wd, rd, er, lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          k;
  logic        seen;

  initial begin
    reset = 1'b1;
    a_valid = 0; a_we = 0; a_adr = 0; a_wdata = 0; a_rsp_ready = 0;
    b_valid = 0; b_we = 0; b_adr = 0; b_wdata = 0; b_rsp_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    // T1: reset state
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_err",   32'(a_rsp_err), 32'd0);
    check("rst_rdata", a_rsp_rdata, 32'd0);

    // T2: store word then load
    xact(0, 4'b1111, 12'h010, 32'hDEADBEEF, rd, er, lat);
    check("st_lat", 32'(lat), 32'd3);
    check("st_rdata", rd, 32'd0);
    check("st_err", 32'(er), 32'd0);
    check("st_idle_ready", 32'(a_ready), 32'd1);
    xact(0, 4'b0000, 12'h010, 32'h0, rd, er, lat);
    check("ld_lat", 32'(lat), 32'd3);
    check("ld_rdata", rd, 32'hDEADBEEF);
    check("ld_err", 32'(er), 32'd0);

    // T3: byte lanes
    xact(0, 4'b1111, 12'h020, 32'h11223344, rd, er, lat);
    xact(0, 4'b0010, 12'h020, 32'h0000AB00, rd, er, lat);
    xact(0, 4'b0000, 12'h020, 32'h0, rd, er, lat);
    check("lane1", rd, 32'h1122AB44);
    xact(0, 4'b1001, 12'h020, 32'hAA0000BB, rd, er, lat);
    xact(0, 4'b0000, 12'h020, 32'h0, rd, er, lat);
    check("lane03", rd, 32'hAA22ABBB);

    // T4: backpressure; a conflicting store is presented while busy and must be ignored
    @(negedge clk);
    a_valid = 1'b1; a_we = 4'b0000; a_adr = 12'h010; a_wdata = 32'h0;
    @(posedge clk); #1;
    a_we = 4'b1111; a_wdata = 32'hBAD0BAD0;
    k = 0;
    while (!a_rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
    check("bp_reached", 32'(a_rsp_valid), 32'd1);
    a_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(a_rsp_valid), 32'd1);
      check("bp_rdata", a_rsp_rdata, 32'hDEADBEEF);
      check("bp_ready", 32'(a_ready), 32'd0);
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    check("bp_done_valid", 32'(a_rsp_valid), 32'd0);
    check("bp_done_ready", 32'(a_ready), 32'd1);
    $display("xact dut=0 backpressured load adr=010 held 5 cycles");
    xact(0, 4'b0000, 12'h010, 32'h0, rd, er, lat);
    check("bp_no_junk", rd, 32'hDEADBEEF);

    // T5: out of range with DEPTH=1024
    xact(0, 4'b1111, 12'h000, 32'h0BADF00D, rd, er, lat);
    xact(0, 4'b1111, 12'h400, 32'h12345678, rd, er, lat);
    check("oor_st_err", 32'(er), 32'd1);
    check("oor_st_rdata", rd, 32'd0);
    check("oor_st_lat", 32'(lat), 32'd3);
    xact(0, 4'b0000, 12'h000, 32'h0, rd, er, lat);
    check("oor_alias", rd, 32'h0BADF00D);
    check("oor_alias_err", 32'(er), 32'd0);
    xact(0, 4'b0000, 12'hFFF, 32'h0, rd, er, lat);
    check("oor_ld_err", 32'(er), 32'd1);
    check("oor_ld_rdata", rd, 32'd0);

    // T6: reset while in WAIT drops the store
    xact(0, 4'b1111, 12'h030, 32'h01020304, rd, er, lat);
    @(negedge clk);
    a_valid = 1'b1; a_we = 4'b1111; a_adr = 12'h030; a_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(a_ready), 32'd1);
    check("mid_rst_valid", 32'(a_rsp_valid), 32'd0);
    check("mid_rst_err",   32'(a_rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; seen = seen | a_rsp_valid; end
    check("mid_rst_no_rsp", 32'(seen), 32'd0);
    $display("xact dut=0 store adr=030 dropped by reset");
    xact(0, 4'b0000, 12'h030, 32'h0, rd, er, lat);
    check("mid_rst_kept", rd, 32'h01020304);

    // T7: zero wait states
    xact(1, 4'b1111, 12'h055, 32'h5A5A5A5A, rd, er, lat);
    check("w0_st_lat", 32'(lat), 32'd1);
    check("w0_st_rdata", rd, 32'd0);
    xact(1, 4'b0000, 12'h055, 32'h0, rd, er, lat);
    check("w0_ld_lat", 32'(lat), 32'd1);
    check("w0_ld_rdata", rd, 32'h5A5A5A5A);
    check("w0_ld_err", 32'(er), 32'd0);
    xact(1, 4'b0100, 12'hFFF, 32'h00C30000, rd, er, lat);
    xact(1, 4'b0000, 12'hFFF, 32'h0, rd, er, lat);
    check("w0_top_err", 32'(er), 32'd0);
    check("w0_top_byte", rd & 32'h00FF0000, 32'h00C30000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the bench itself wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
